// File: rtl/sram_pack_writer_if.sv
// Bus between the 9-bit sample source, the packing writer and the SRAM write stage.
// The master side drives samples and control; the slave side is the packing writer.
interface sram_pack_writer_if;
    logic        start;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        ry;
    logic        we_n;
    logic [7:0]  w_addr;
    logic [31:0] write_data;
    logic        full;
    logic [8:0]  word_count;

    modport master (
        output start, in_valid, in_data, flush, ry,
        input  in_ready, we_n, w_addr, write_data, full, word_count
    );

    modport slave (
        input  start, in_valid, in_data, flush, ry,
        output in_ready, we_n, w_addr, write_data, full, word_count
    );
endinterface

// File: rtl/sram_pack_writer.sv
// Packs pairs of 9-bit samples into 32-bit SRAM words (low sample in [8:0],
// high sample in [17:9], upper bits zero) and writes them to consecutive
// addresses starting at BASE_ADDR until NUM_WORDS words have been written.
// A flush in the high-sample phase closes a half-filled word with a zero
// upper sample. Each word gets a single-cycle active-low write strobe, then
// the block waits for the SRAM ready before moving on.
module sram_pack_writer #(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         NUM_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_pack_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WR   = 3'd3,
        ST_WAIT = 3'd4,
        ST_FULL = 3'd5
    } state_t;

    // Count value held while the final word of the run is in flight.
    localparam logic [8:0] LAST_COUNT = 9'(NUM_WORDS - 1);

    state_t      state_q;
    logic [7:0]  addr_q;
    logic [17:0] data_q;
    logic [8:0]  count_q;
    logic        full_q;
    logic        we_n_q;
    logic        in_ready_q;

    logic        xfer_s;
    logic        last_word_s;

    // in_ready_q is high exactly in the two sample-collecting states, so it
    // doubles as the "this state accepts a sample" qualifier.
    assign xfer_s      = bus.in_valid & in_ready_q;
    assign last_word_s = (count_q == LAST_COUNT);

    // Packing FSM: state, address, word buffer, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            data_q     <= 18'd0;
            count_q    <= 9'd0;
            full_q     <= 1'b0;
            we_n_q     <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FULL: begin
                    // Arm a new run; the word buffer keeps its old content
                    // until the first sample overwrites it.
                    if (bus.start) begin
                        state_q    <= ST_LO;
                        addr_q     <= BASE_ADDR;
                        count_q    <= 9'd0;
                        full_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        we_n_q     <= 1'b1;
                    end else begin
                        state_q    <= state_q;
                    end
                end

                ST_LO: begin
                    // Flush is meaningless with nothing captured, so only a transfer moves us on.
                    if (xfer_s) begin
                        data_q[8:0] <= bus.in_data;
                        state_q     <= ST_HI;
                    end else begin
                        state_q     <= ST_LO;
                    end
                end

                ST_HI: begin
                    // A real sample wins over flush when both arrive together.
                    if (xfer_s) begin
                        data_q[17:9] <= bus.in_data;
                        state_q      <= ST_WR;
                        in_ready_q   <= 1'b0;
                        we_n_q       <= 1'b0;
                    end else if (bus.flush) begin
                        data_q[17:9] <= 9'd0;
                        state_q      <= ST_WR;
                        in_ready_q   <= 1'b0;
                        we_n_q       <= 1'b0;
                    end else begin
                        state_q      <= ST_HI;
                    end
                end

                ST_WR: begin
                    // The strobe was raised on entry; drop it after one cycle.
                    we_n_q  <= 1'b1;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Address and data stay frozen until the SRAM acknowledges.
                    if (bus.ry) begin
                        count_q <= count_q + 9'd1;
                        if (last_word_s) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            addr_q     <= addr_q + 8'd1;
                            state_q    <= ST_LO;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    full_q     <= 1'b0;
                    we_n_q     <= 1'b1;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.we_n       = we_n_q;
    assign bus.w_addr     = addr_q;
    assign bus.write_data = {14'd0, data_q};
    assign bus.full       = full_q;
    assign bus.word_count = count_q;

endmodule

// File: doc/sram_pack_writer.md
SRAM_PACK_WRITER -- requirements
Module: sram_pack_writer

Interface
REQ-001 Parameter BASE_ADDR, default 8'd0, first SRAM word address written after start.
REQ-002 Parameter NUM_WORDS, default 256, number of words written before full (1..256; BASE_ADDR+NUM_WORDS-1 <= 255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; arms block, loads address counter with BASE_ADDR.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  9  upstream 9-bit sample.
REQ-008 in_ready  output  1  block accepts sample this cycle.
REQ-009 flush  input  1  write a half-filled word immediately, upper sample zero.
REQ-010 ry  input  1  SRAM ready from memory wrapper.
REQ-011 we_n  output  1  active-low write enable to SRAM stage.
REQ-012 w_addr  output  8  SRAM write address.
REQ-013 write_data  output  32  packed word to SRAM.
REQ-014 full  output  1  NUM_WORDS words written; no further writes until start.
REQ-015 word_count  output  9  words written since last start.

Function
REQ-016 States: IDLE, LO, HI, WR, WAIT, FULL; encoding free.
REQ-017 Transfer occurs on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in LO and HI, independent of in_valid.
REQ-018 IDLE: start=1 -> LO, w_addr<=BASE_ADDR, word_count<=0, full<=0; otherwise stay.
REQ-019 LO: transfer -> capture in_data into write_data[8:0], go HI; flush in LO ignored.
REQ-020 HI: transfer -> capture in_data into write_data[17:9], go WR; transfer has priority over flush in the same cycle.
REQ-021 HI: flush=1 without transfer -> write_data[17:9]<=0, go WR.
REQ-022 write_data[31:18] SHALL be 0 always.
REQ-023 WR: we_n=0 for exactly this one cycle, then go WAIT; we_n=1 in every other state.
REQ-024 w_addr and write_data SHALL be held stable from entry to WR until exit from WAIT.
REQ-025 WAIT: stay while ry=0; on ry=1, word_count+=1 and, if word_count (before increment) = NUM_WORDS-1 -> FULL, else w_addr+=1 and -> LO.
REQ-026 w_addr increments modulo 256; no wrap beyond BASE_ADDR+NUM_WORDS-1 occurs.
REQ-027 FULL: full=1, in_ready=0, we_n=1; start=1 -> same action as REQ-018.
REQ-028 start in LO, HI, WR or WAIT SHALL be ignored; a started word always completes.
REQ-029 Minimum word period: 4 cycles (LO, HI, WR, WAIT with ry=1).
REQ-030 in_data is not registered when no transfer occurs; write_data bits hold previous value.

Reset
REQ-031 rst_n=0 at a rising edge: state<=IDLE, w_addr<=BASE_ADDR, write_data<=0, word_count<=0, full<=0; we_n=1, in_ready=0 from that edge.
REQ-032 Reset SHALL override all inputs including start and abort any in-progress word without a write pulse after the reset edge.
REQ-033 After rst_n returns high, no write occurs until start.

Verification
REQ-034 Reset, start, samples 9'h1A5 then 9'h0F3, ry=1 -> one we_n low cycle, w_addr=8'h00, write_data=32'h0001E7A5, word_count=1.
REQ-035 Sample 9'h155, flush=1 in HI, no in_valid -> write_data=32'h00000155, single we_n pulse.
REQ-036 ry held 0 for 5 cycles in WAIT -> in_ready=0, w_addr/write_data stable, we_n=1, advance on cycle ry=1.
REQ-037 NUM_WORDS=4, BASE_ADDR=8'hFC, 8 samples -> addresses FC,FD,FE,FF, full=1, word_count=4, in_ready=0; start -> w_addr=8'hFC, full=0.
REQ-038 rst_n=0 while in WAIT -> IDLE, we_n=1, word_count=0, no later write until start.
REQ-039 in_valid=1 and flush=1 together in HI with in_data=9'h1FF -> write_data[17:9]=9'h1FF.
